// File: rtl/msg_ram_writer_if.sv
// Byte-stream load handshake, status and replay read port of msg_ram_writer.
// master = stream source / replay reader, slave = the writer itself.
interface msg_ram_writer_if #(
    parameter int DW = 8,
    parameter int AW = 6
) ();
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   wr_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output start, in_valid, in_data, rd_en, rd_addr,
        input  in_ready, busy, done, overflow, wr_count, rd_data
    );

    modport slave (
        input  start, in_valid, in_data, rd_en, rd_addr,
        output in_ready, busy, done, overflow, wr_count, rd_data
    );
endinterface

// File: rtl/msg_ram_writer.sv
// Captures a terminated byte message into a 64x8 RAM with self-generated write
// addresses; a registered read port replays it with the character-ROM timing.
module msg_ram_writer #(
    parameter int            DW   = 8,
    parameter int            AW   = 6,
    parameter logic [DW-1:0] TERM = '0
) (
    input logic            clk,
    input logic            rst_n,
    msg_ram_writer_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] mem [DEPTH];

    logic accept;
    logic start_load;
    logic term_hit;
    logic ram_full;
    logic last_byte;
    logic in_ready_c, busy_c, done_c;

    assign term_hit  = (bus.in_data == TERM);
    assign ram_full  = (ptr_q == '1);
    assign last_byte = term_hit | ram_full;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        start_load = 1'b0;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    start_load = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (last_byte) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    start_load = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Pointer parks on the final address so it can never wrap past the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (start_load) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= cnt_q + (AW + 1)'(1);
            ovf_q <= ~term_hit & ram_full;
            if (!last_byte) ptr_q <= ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[ptr_q] <= bus.in_data;
    end

    // Non-blocking read of the old word gives read-before-write on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rd_data_q <= '0;
        else if (bus.rd_en)  rd_data_q <= mem[bus.rd_addr];
    end

    assign bus.in_ready = in_ready_c;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.overflow = ovf_q;
    assign bus.wr_count = cnt_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_msg_ram_writer.sv
// Randomized scoreboard bench for msg_ram_writer: a reference memory model
// predicts load status and read data, a monitor checks every read response.
module tb_msg_ram_writer;
    logic clk;
    logic rst_n;

    msg_ram_writer_if #(.DW(8), .AW(6)) ifc ();

    msg_ram_writer #(.DW(8), .AW(6), .TERM(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [64];
    logic [7:0] exp_q [$];
    logic [7:0] seen [$];
    logic [7:0] last_exp = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: a read issued at an edge is presented one clock later.
    initial begin
        logic pend;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            pend = ifc.rd_en && rst_n;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 32'(ifc.rd_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(ifc.rd_data), 32'(e));
                    last_exp = e;
                    seen.push_back(ifc.rd_data);
                end
            end else if (rst_n) begin
                check("rd_hold", 32'(ifc.rd_data), 32'(last_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        @(negedge clk);
        check("start_busy", 32'(ifc.busy), 32'd1);
        check("start_done", 32'(ifc.done), 32'd0);
        check("start_cnt", 32'(ifc.wr_count), 32'd0);
        check("start_ovf", 32'(ifc.overflow), 32'd0);
        step();
    endtask

    // Offer msg byte by byte; model: stored bytes end at first terminator or at 64.
    task automatic load(input logic [7:0] msg[$], input bit gaps, input int col_idx);
        int exp_n = 0;
        bit term  = 0;
        int acc;
        foreach (msg[k]) begin
            if (exp_n < 64 && !term) begin
                exp_n++;
                if (msg[k] == 8'h00) term = 1;
            end
        end
        do_start();
        for (int i = 0; i < msg.size(); i++) begin
            acc = (i < exp_n) ? i : exp_n;
            if (gaps) begin
                ifc.in_valid = 1'b0;
                ifc.in_data  = 8'($urandom);
                ifc.start    = (acc < exp_n) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                check("gap_cnt", 32'(ifc.wr_count), 32'(acc));
                check("gap_ready", 32'(ifc.in_ready), 32'(acc < exp_n));
                step();
                ifc.start = 1'b0;
            end
            ifc.in_valid = 1'b1;
            ifc.in_data  = msg[i];
            ifc.rd_en    = 1'b0;
            if (col_idx >= 0 && (i == col_idx || i == col_idx + 1)) begin
                ifc.rd_en   = 1'b1;
                ifc.rd_addr = 6'(col_idx);
                exp_q.push_back(ref_mem[col_idx]);
            end
            @(negedge clk);
            check("ld_cnt", 32'(ifc.wr_count), 32'(acc));
            check("ld_ready", 32'(ifc.in_ready), 32'(acc < exp_n));
            if (acc < exp_n) ref_mem[acc] = msg[i];
            step();
        end
        ifc.in_valid = 1'b0;
        ifc.rd_en    = 1'b0;
        @(negedge clk);
        check("end_done", 32'(ifc.done), 32'd1);
        check("end_busy", 32'(ifc.busy), 32'd0);
        check("end_ready", 32'(ifc.in_ready), 32'd0);
        check("end_ovf", 32'(ifc.overflow), 32'(!term));
        check("end_cnt", 32'(ifc.wr_count), 32'(exp_n));
        step();
    endtask

    task automatic readback(input int n);
        int order[$];
        for (int a = 0; a < n; a++) order.push_back(a);
        order.shuffle();
        foreach (order[k]) begin
            ifc.rd_en   = 1'b1;
            ifc.rd_addr = 6'(order[k]);
            exp_q.push_back(ref_mem[order[k]]);
            step();
            ifc.rd_en = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                ifc.rd_addr = 6'($urandom);
                step();
            end
        end
        ifc.rd_en = 1'b0;
        step();
    endtask

    task automatic rand_msg(output logic [7:0] m[$]);
        int len = $urandom_range(1, 80);
        m = {};
        for (int k = 0; k < len; k++) m.push_back(8'($urandom_range(1, 255)));
        if ($urandom_range(0, 3) != 0) m[$urandom_range(0, len - 1)] = 8'h00;
    endtask

    initial begin
        logic [7:0] msg[$];
        string s;
        int cnt;
        rst_n        = 1'b1;
        ifc.start    = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        ifc.rd_en    = 1'b0;
        ifc.rd_addr  = 6'd0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ifc.in_ready), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_ovf", 32'(ifc.overflow), 32'd0);
        check("rst_cnt", 32'(ifc.wr_count), 32'd0);
        check("rst_rd", 32'(ifc.rd_data), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ifc.in_ready), 32'd0);
        check("idle_done", 32'(ifc.done), 32'd0);
        step();

        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h00};
        load(msg, 0, -1);
        readback(6);

        // Tick-paced replay: rd_en every 10th clock, 6-bit address counter.
        seen = {};
        cnt  = 0;
        for (int k = 0; k < 60; k++) begin
            ifc.rd_en = (k % 10 == 9);
            if (ifc.rd_en) begin
                ifc.rd_addr = 6'(cnt);
                exp_q.push_back(ref_mem[cnt]);
                cnt++;
            end
            step();
        end
        ifc.rd_en = 1'b0;
        repeat (2) step();
        s = "";
        foreach (seen[k]) if (seen[k] != 8'h00) s = {s, string'(seen[k])};
        $display("replay: %s", s);

        msg = '{8'h41, 8'h42, 8'h00};
        load(msg, 1, -1);
        readback(3);

        msg = {};
        for (int k = 0; k < 70; k++) msg.push_back(8'($urandom_range(1, 255)));
        load(msg, 0, -1);
        readback(64);

        msg = {};
        for (int k = 0; k < 63; k++) msg.push_back(8'($urandom_range(1, 255)));
        msg.push_back(8'h00);
        load(msg, 0, -1);
        readback(64);

        msg = '{8'h61, 8'h62, 8'h63, 8'h11, 8'h64, 8'h00};
        load(msg, 0, -1);
        msg = '{8'h71, 8'h72, 8'h73, 8'h5A, 8'h74, 8'h00};
        load(msg, 0, 3);
        readback(6);

        // Reset in the middle of a load keeps already written bytes.
        do_start();
        for (int k = 0; k < 3; k++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 8'h78 + 8'(k);
            ref_mem[k]   = 8'h78 + 8'(k);
            step();
        end
        ifc.in_data = 8'h51;
        #2 rst_n = 1'b0;
        last_exp = 8'h00;
        #1;
        check("mid_rst_busy", 32'(ifc.busy), 32'd0);
        check("mid_rst_ready", 32'(ifc.in_ready), 32'd0);
        check("mid_rst_cnt", 32'(ifc.wr_count), 32'd0);
        check("mid_rst_rd", 32'(ifc.rd_data), 32'd0);
        ifc.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ifc.in_ready), 32'd0);
        check("post_rst_done", 32'(ifc.done), 32'd0);
        step();
        readback(3);

        for (int r = 0; r < 6; r++) begin
            rand_msg(msg);
            load(msg, 1'($urandom_range(0, 1)), -1);
            readback((msg.size() > 64) ? 64 : msg.size());
        end

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "bench timeout");
    end
endmodule
